// File: rtl/smac_seq_ctrl.sv
// Job sequencer for one SubMAC precision-split DSP chain: clear, gated beats, pipeline flush, done.
// Optional stall counter is built only when SMAC_SEQ_CTRL_PERF_CNT_EN is defined.
module smac_seq_ctrl #(
   parameter int CNT_W       = 16,
   parameter int DSP_LATENCY = 3
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             start,
   input  logic [1:0]       prec_mode,
   input  logic [1:0]       fp_mode,
   input  logic [CNT_W-1:0] beat_count,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             smac_ce,
   output logic             smac_sclr,
   output logic [3:0]       select_precision,
   output logic [1:0]       enable_fp_unit,
   output logic             active_chain,
   output logic             operand_zero,
   output logic [CNT_W-1:0] beats_done,
   output logic [31:0]      perf_stall_cnt
);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [3:0]       DRAIN_LAST = 4'(DSP_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] beat_cnt_q;
   logic [3:0]       drain_cnt_q;
   logic             abort_take;
   logic             beat_fire;
   logic             job_start;
   logic [3:0]       mask_d;

   assign job_start = (state_q == S_IDLE) && start;
   assign beat_fire = (state_q == S_RUN) && in_valid;
   assign in_ready  = (state_q == S_RUN);
   assign smac_ce   = beat_fire || (state_q == S_DRAIN);

   always_comb begin
      mask_d = 4'b0001;
      case (prec_mode)
         2'd0:    mask_d = 4'b0001;
         2'd1:    mask_d = 4'b0011;
         2'd2:    mask_d = 4'b0111;
         default: mask_d = 4'b1111;
      endcase
   end

   // Abort overrides every transition except when already idle.
   always_comb begin
      state_d    = state_q;
      abort_take = 1'b0;
      case (state_q)
         S_IDLE:  if (start) state_d = S_CLEAR;
         S_CLEAR: state_d = (beat_cnt_q != '0) ? S_RUN : S_DONE;
         S_RUN:   if (in_valid && (beats_done == beat_cnt_q - CNT_ONE)) state_d = S_DRAIN;
         S_DRAIN: if (drain_cnt_q == DRAIN_LAST) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort && (state_q != S_IDLE)) begin
         state_d    = S_IDLE;
         abort_take = 1'b1;
      end
   end

   // Registered status outputs are derived from the next state so they line up with the state.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q          <= S_IDLE;
         busy             <= 1'b0;
         done             <= 1'b0;
         smac_sclr        <= 1'b0;
         operand_zero     <= 1'b0;
         select_precision <= 4'b0000;
         enable_fp_unit   <= 2'b00;
         active_chain     <= 1'b0;
         beat_cnt_q       <= '0;
         beats_done       <= '0;
         drain_cnt_q      <= 4'd0;
      end else begin
         state_q      <= state_d;
         busy         <= (state_d != S_IDLE);
         done         <= (state_d == S_DONE);
         smac_sclr    <= (state_d == S_CLEAR) || abort_take;
         operand_zero <= (state_d == S_DRAIN);
         drain_cnt_q  <= (state_q == S_DRAIN) ? drain_cnt_q + 4'd1 : 4'd0;
         if (job_start) begin
            select_precision <= mask_d;
            enable_fp_unit   <= fp_mode;
            active_chain     <= (prec_mode != 2'd0);
            beat_cnt_q       <= beat_count;
            beats_done       <= '0;
         end else if (beat_fire && (beats_done != '1)) begin
            beats_done <= beats_done + CNT_ONE;
         end
      end
   end

`ifdef SMAC_SEQ_CTRL_PERF_CNT_EN
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         perf_stall_cnt <= 32'd0;
      end else if (job_start) begin
         perf_stall_cnt <= 32'd0;
      end else if ((state_q == S_RUN) && !in_valid && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
         perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`else
   assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_smac_seq_ctrl.sv
// Self-checking bench for smac_seq_ctrl: per-cycle expectations come from a timeline model
// built from the drawn in_valid pattern (CLEAR at cycle 1, RUN until the n-th beat, L drain cycles, DONE).
module tb_smac_seq_ctrl;

   localparam int CNT_W = 16;
   localparam int L     = 3;

   logic             clk;
   logic             aresetn;
   logic             start;
   logic [1:0]       prec_mode;
   logic [1:0]       fp_mode;
   logic [CNT_W-1:0] beat_count;
   logic             abort;
   logic             in_valid;
   logic             in_ready;
   logic             busy;
   logic             done;
   logic             smac_ce;
   logic             smac_sclr;
   logic [3:0]       select_precision;
   logic [1:0]       enable_fp_unit;
   logic             active_chain;
   logic             operand_zero;
   logic [CNT_W-1:0] beats_done;
   logic [31:0]      perf_stall_cnt;

   int checks;
   int errors;

   smac_seq_ctrl #(.CNT_W(CNT_W), .DSP_LATENCY(L)) dut (
      .clk              (clk),
      .aresetn          (aresetn),
      .start            (start),
      .prec_mode        (prec_mode),
      .fp_mode          (fp_mode),
      .beat_count       (beat_count),
      .abort            (abort),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .busy             (busy),
      .done             (done),
      .smac_ce          (smac_ce),
      .smac_sclr        (smac_sclr),
      .select_precision (select_precision),
      .enable_fp_unit   (enable_fp_unit),
      .active_chain     (active_chain),
      .operand_zero     (operand_zero),
      .beats_done       (beats_done),
      .perf_stall_cnt   (perf_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   // Runs one complete job and checks every cycle against the timeline model.
   task automatic run_job(input string tag, input logic [1:0] prec, input logic [1:0] fp,
                          input int n, input int pct, input int fixed_len,
                          input logic [15:0] fixed_pat, input bit poke_start);
      bit       pat [0:299];
      int       seen, last, done_idx, stalls, acc, p;
      bit       v, exp_run, exp_drain, exp_ce;
      logic [3:0]  exp_mask;
      logic        exp_chain;
      logic [31:0] exp_perf;
      p         = int'(prec);
      exp_mask  = 4'((1 << (p + 1)) - 1);
      exp_chain = (p != 0);
      seen = 0;
      last = 1;
      for (int k = 0; k < 300; k++) pat[k] = 1'b0;
      pat[1] = 1'($urandom_range(1));
      for (int k = 2; k < 250 && seen < n; k++) begin
         if (fixed_len > 0) v = (k - 2 < fixed_len) ? fixed_pat[k-2] : 1'b1;
         else               v = (k > 200) ? 1'b1 : ($urandom_range(99) < pct);
         pat[k] = v;
         if (v) begin
            seen++;
            if (seen == n) last = k;
         end
      end
      for (int k = last + 1; k < 300; k++) pat[k] = 1'($urandom_range(1));
      stalls = 0;
      for (int k = 2; k < last; k++) if (!pat[k]) stalls++;
      done_idx = (n == 0) ? 2 : last + L + 1;
      acc = 0;

      @(negedge clk);
      start      = 1'b1;
      prec_mode  = prec;
      fp_mode    = fp;
      beat_count = 16'(n);
      in_valid   = 1'b0;
      for (int k = 1; k <= done_idx + 1; k++) begin
         @(negedge clk);
         start = (poke_start && k == 3);
         if (poke_start && k >= 3) begin
            prec_mode  = ~prec;
            fp_mode    = ~fp;
            beat_count = 16'($urandom_range(50));
         end
         in_valid = pat[k];
         #1;
         exp_run   = (n > 0) && (k >= 2) && (k <= last);
         exp_drain = (n > 0) && (k > last) && (k <= last + L);
         exp_ce    = (exp_run && pat[k]) || exp_drain;
         checks++;
         if (in_ready !== exp_run) begin
            errors++;
            $display("[TB] FAIL %s in_ready k=%0d got %b want %b", tag, k, in_ready, exp_run);
         end
         checks++;
         if (smac_ce !== exp_ce) begin
            errors++;
            $display("[TB] FAIL %s smac_ce k=%0d got %b want %b", tag, k, smac_ce, exp_ce);
         end
         checks++;
         if (operand_zero !== exp_drain) begin
            errors++;
            $display("[TB] FAIL %s operand_zero k=%0d got %b want %b", tag, k, operand_zero, exp_drain);
         end
         checks++;
         if (smac_sclr !== (k == 1)) begin
            errors++;
            $display("[TB] FAIL %s smac_sclr k=%0d got %b want %b", tag, k, smac_sclr, (k == 1));
         end
         checks++;
         if (done !== (k == done_idx)) begin
            errors++;
            $display("[TB] FAIL %s done k=%0d got %b want %b", tag, k, done, (k == done_idx));
         end
         checks++;
         if (busy !== (k <= done_idx)) begin
            errors++;
            $display("[TB] FAIL %s busy k=%0d got %b want %b", tag, k, busy, (k <= done_idx));
         end
         checks++;
         if (beats_done !== 16'(acc)) begin
            errors++;
            $display("[TB] FAIL %s beats_done k=%0d got %0d want %0d", tag, k, beats_done, acc);
         end
         checks++;
         if (select_precision !== exp_mask || active_chain !== exp_chain || enable_fp_unit !== fp) begin
            errors++;
            $display("[TB] FAIL %s config k=%0d got mask=%b chain=%b fp=%b want mask=%b chain=%b fp=%b",
                     tag, k, select_precision, active_chain, enable_fp_unit, exp_mask, exp_chain, fp);
         end
         if (exp_run && pat[k]) acc++;
      end
      in_valid = 1'b0;
`ifdef SMAC_SEQ_CTRL_PERF_CNT_EN
      exp_perf = 32'(stalls);
`else
      exp_perf = 32'd0;
`endif
      checks++;
      if (perf_stall_cnt !== exp_perf) begin
         errors++;
         $display("[TB] FAIL %s perf_stall_cnt got %0d want %0d", tag, perf_stall_cnt, exp_perf);
      end
      checks++;
      if (beats_done !== 16'(n)) begin
         errors++;
         $display("[TB] FAIL %s final beats_done got %0d want %0d", tag, beats_done, n);
      end
   endtask

   task automatic test_reset();
      aresetn    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      in_valid   = 1'b0;
      prec_mode  = 2'd0;
      fp_mode    = 2'd0;
      beat_count = '0;
      #1;
      checks++;
      if ({in_ready, busy, done, smac_ce, smac_sclr, operand_zero, active_chain} !== 7'b0 ||
          select_precision !== 4'b0 || enable_fp_unit !== 2'b0 || beats_done !== '0 || perf_stall_cnt !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_initial outputs not at reset values busy=%b sel=%b bd=%0d", busy, select_precision, beats_done);
      end
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
      // Start a 5-beat job and pull reset during the second beat.
      @(negedge clk);
      start      = 1'b1;
      prec_mode  = 2'd2;
      fp_mode    = 2'd3;
      beat_count = 16'd5;
      in_valid   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      aresetn = 1'b0;
      #1;
      checks++;
      if ({in_ready, busy, done, smac_ce, smac_sclr, operand_zero, active_chain} !== 7'b0 ||
          select_precision !== 4'b0 || enable_fp_unit !== 2'b0 || beats_done !== '0 || perf_stall_cnt !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_midrun got ready=%b busy=%b ce=%b sel=%b bd=%0d want all zero",
                  in_ready, busy, smac_ce, select_precision, beats_done);
      end
      @(negedge clk);
      aresetn  = 1'b1;
      in_valid = 1'b0;
      run_job("after_reset", 2'd1, 2'd2, 5, 100, 0, 16'h0, 1'b0);
   endtask

   task automatic test_prec_modes();
      run_job("int8_4beats", 2'd0, 2'd0, 4, 100, 0, 16'h0, 1'b0);
      run_job("int16", 2'd1, 2'd1, 6, 70, 0, 16'h0, 1'b0);
      run_job("int32", 2'd2, 2'd2, 3, 50, 0, 16'h0, 1'b0);
   endtask

   task automatic test_stall_pattern();
      run_job("int64_stalls", 2'd3, 2'd1, 3, 0, 5, 16'b11001, 1'b0);
   endtask

   task automatic test_zero_beats();
      run_job("zero_beats", 2'd2, 2'd3, 0, 100, 0, 16'h0, 1'b0);
   endtask

   task automatic test_start_ignored();
      run_job("start_ignored", 2'd1, 2'd1, 5, 80, 0, 16'h0, 1'b1);
   endtask

   task automatic test_abort();
      // Abort in the second drain cycle of a two-beat job.
      @(negedge clk);
      start      = 1'b1;
      prec_mode  = 2'd2;
      fp_mode    = 2'd1;
      beat_count = 16'd2;
      in_valid   = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         start = 1'b0;
         abort = (k == 5);
         #1;
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_drain done k=%0d got %b want 0", k, done);
         end
         if (k == 5) begin
            checks++;
            if (operand_zero !== 1'b1) begin
               errors++;
               $display("[TB] FAIL abort_drain in_drain k=5 operand_zero got %b want 1", operand_zero);
            end
         end
         if (k == 6) begin
            checks++;
            if (busy !== 1'b0 || smac_sclr !== 1'b1 || in_ready !== 1'b0 || smac_ce !== 1'b0 || beats_done !== 16'd2) begin
               errors++;
               $display("[TB] FAIL abort_drain after got busy=%b sclr=%b ready=%b ce=%b bd=%0d want 0 1 0 0 2",
                        busy, smac_sclr, in_ready, smac_ce, beats_done);
            end
         end
         if (k == 7) begin
            checks++;
            if (smac_sclr !== 1'b0 || busy !== 1'b0) begin
               errors++;
               $display("[TB] FAIL abort_drain sclr_width got sclr=%b busy=%b want 0 0", smac_sclr, busy);
            end
         end
      end
      abort = 1'b0;

      // Abort in RUN after two beats: count must hold.
      @(negedge clk);
      start      = 1'b1;
      beat_count = 16'd10;
      in_valid   = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start    = 1'b0;
         in_valid = (k < 4);
         abort    = (k == 4);
         #1;
         if (k == 5) begin
            checks++;
            if (busy !== 1'b0 || smac_sclr !== 1'b1 || beats_done !== 16'd2 || done !== 1'b0) begin
               errors++;
               $display("[TB] FAIL abort_run got busy=%b sclr=%b bd=%0d done=%b want 0 1 2 0",
                        busy, smac_sclr, beats_done, done);
            end
         end
      end
      abort = 1'b0;

      // Abort while idle does nothing.
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      checks++;
      if (smac_sclr !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_idle got sclr=%b busy=%b want 0 0", smac_sclr, busy);
      end

      // Start and abort together in IDLE: start wins.
      @(negedge clk);
      start      = 1'b1;
      abort      = 1'b1;
      beat_count = 16'd3;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b1 || smac_sclr !== 1'b1) begin
         errors++;
         $display("[TB] FAIL start_abort_idle got busy=%b sclr=%b want 1 1", busy, smac_sclr);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || smac_sclr !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_clear got busy=%b sclr=%b done=%b want 0 1 0", busy, smac_sclr, done);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int j = 0; j < 12; j++) begin
         run_job("random", 2'($urandom_range(3)), 2'($urandom_range(3)),
                 int'($urandom_range(12)), int'($urandom_range(100, 30)), 0, 16'h0, 1'b0);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_prec_modes();
      test_stall_pattern();
      test_zero_beats();
      test_abort();
      test_start_ignored();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
